// File: rtl/id_operand_stage_pkg.sv
// Shared constants, types and decode helpers for the ID operand stage.
//
// Contents:
//   WORD_DATA_BUS / REG_ADDR_BUS  datapath and register-address widths
//   ENABLE_ / DISABLE_            active-low enable encoding used by gpr
//   OP_*                          RV32I major opcodes the stage cares about
//   ISA_NOP                       canonical NOP (addi x0, x0, 0)
//   id_ex_t                       contents of the ID/EX pipeline register
//   uses_rs1/uses_rs2/writes_rd   opcode-based operand/destination usage
package id_operand_stage_pkg;

    localparam int WORD_DATA_BUS = 32;
    localparam int REG_ADDR_BUS  = 5;

    // The gpr write port is active-low, so "enabled" is a 0.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    localparam logic [WORD_DATA_BUS-1:0] ISA_NOP = 32'h0000_0013;

    typedef struct packed {
        logic                     valid;
        logic [WORD_DATA_BUS-1:0] pc;
        logic [WORD_DATA_BUS-1:0] insn;
        logic [WORD_DATA_BUS-1:0] ra_data;
        logic [WORD_DATA_BUS-1:0] rb_data;
        logic [REG_ADDR_BUS-1:0]  dst_addr;
        logic                     gpr_we_;
    } id_ex_t;

    localparam id_ex_t ID_EX_RESET = '{
        valid:    1'b0,
        pc:       '0,
        insn:     ISA_NOP,
        ra_data:  '0,
        rb_data:  '0,
        dst_addr: '0,
        gpr_we_:  DISABLE_
    };

    // U-type and JAL encodings carry immediate bits in the rs1 field.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    endfunction

    // Only these formats have a real rs2; elsewhere the field is immediate.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

    function automatic logic writes_rd(input logic [6:0] opcode,
                                       input logic [REG_ADDR_BUS-1:0] rd);
        return (opcode != OP_STORE) && (opcode != OP_BRANCH) && (rd != '0);
    endfunction

endpackage

// File: rtl/id_operand_stage_fwd_mux.sv
// id_fwd_mux: per-operand bypass selection.
//
// Ports:
//   src_addr      in   source register number
//   gpr_data      in   register file read value
//   ex_fwd_en     in   EX holds a valid register-writing instruction
//   ex_is_load    in   that EX instruction is a load (data not ready yet)
//   ex_dst_addr   in   EX destination register
//   ex_fwd_data   in   EX ALU result
//   mem_fwd_en    in   MEM result is forwardable
//   mem_dst_addr  in   MEM destination register
//   mem_fwd_data  in   MEM result
//   fwd_data      out  resolved operand value
module id_fwd_mux
    import id_operand_stage_pkg::*;
(
    input  logic [REG_ADDR_BUS-1:0]  src_addr,
    input  logic [WORD_DATA_BUS-1:0] gpr_data,
    input  logic                     ex_fwd_en,
    input  logic                     ex_is_load,
    input  logic [REG_ADDR_BUS-1:0]  ex_dst_addr,
    input  logic [WORD_DATA_BUS-1:0] ex_fwd_data,
    input  logic                     mem_fwd_en,
    input  logic [REG_ADDR_BUS-1:0]  mem_dst_addr,
    input  logic [WORD_DATA_BUS-1:0] mem_fwd_data,
    output logic [WORD_DATA_BUS-1:0] fwd_data
);

    always_comb begin
        // NOTE: default first so every path assigns fwd_data and no latch is inferred.
        fwd_data = gpr_data;
        if (src_addr == '0) begin
            // x0 must never pick up a bypassed value, even if some stage "writes" it.
            fwd_data = '0;
        end else if (ex_fwd_en && !ex_is_load && (ex_dst_addr == src_addr)) begin
            // The youngest producer wins; a load in EX has no data yet.
            fwd_data = ex_fwd_data;
        end else if (mem_fwd_en && (mem_dst_addr == src_addr)) begin
            fwd_data = mem_fwd_data;
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: decode / operand fetch between IF/ID and EX.
//
// Ports:
//   clk, reset                 pipeline clock, synchronous active-high reset
//   if_valid/if_pc/if_insn     IF/ID slot contents
//   stall                      hold the ID/EX register
//   flush                      kill the ID/EX contents
//   gpr_rd_addr_0/1            out: rs1/rs2 read addresses (combinational)
//   gpr_rd_data_0/1            in:  register file read data
//   ex_fwd_en/ex_is_load/ex_dst_addr/ex_fwd_data   EX bypass source
//   mem_fwd_en/mem_dst_addr/mem_fwd_data           MEM bypass source
//   ld_hazard                  out: load-use stall request (combinational)
//   id_valid/id_pc/id_insn/id_ra_data/id_rb_data/id_dst_addr/id_gpr_we_
//                              out: ID/EX register contents
module id_operand_stage
    import id_operand_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     if_valid,
    input  logic [WORD_DATA_BUS-1:0] if_pc,
    input  logic [WORD_DATA_BUS-1:0] if_insn,
    input  logic                     stall,
    input  logic                     flush,
    output logic [REG_ADDR_BUS-1:0]  gpr_rd_addr_0,
    output logic [REG_ADDR_BUS-1:0]  gpr_rd_addr_1,
    input  logic [WORD_DATA_BUS-1:0] gpr_rd_data_0,
    input  logic [WORD_DATA_BUS-1:0] gpr_rd_data_1,
    input  logic                     ex_fwd_en,
    input  logic                     ex_is_load,
    input  logic [REG_ADDR_BUS-1:0]  ex_dst_addr,
    input  logic [WORD_DATA_BUS-1:0] ex_fwd_data,
    input  logic                     mem_fwd_en,
    input  logic [REG_ADDR_BUS-1:0]  mem_dst_addr,
    input  logic [WORD_DATA_BUS-1:0] mem_fwd_data,
    output logic                     ld_hazard,
    output logic                     id_valid,
    output logic [WORD_DATA_BUS-1:0] id_pc,
    output logic [WORD_DATA_BUS-1:0] id_insn,
    output logic [WORD_DATA_BUS-1:0] id_ra_data,
    output logic [WORD_DATA_BUS-1:0] id_rb_data,
    output logic [REG_ADDR_BUS-1:0]  id_dst_addr,
    output logic                     id_gpr_we_
);

    logic [6:0]               opcode;
    logic [REG_ADDR_BUS-1:0]  rs1_addr;
    logic [REG_ADDR_BUS-1:0]  rs2_addr;
    logic [REG_ADDR_BUS-1:0]  rd_addr;
    logic [WORD_DATA_BUS-1:0] ra_data;
    logic [WORD_DATA_BUS-1:0] rb_data;
    logic                     rs1_conflict;
    logic                     rs2_conflict;
    logic                     gpr_we_dec;
    id_ex_t                   id_ex_q;

    assign opcode   = if_insn[6:0];
    assign rd_addr  = if_insn[11:7];
    assign rs1_addr = if_insn[19:15];
    assign rs2_addr = if_insn[24:20];

    assign gpr_rd_addr_0 = rs1_addr;
    assign gpr_rd_addr_1 = rs2_addr;

    id_fwd_mux u_fwd_ra (
        .src_addr     (rs1_addr),
        .gpr_data     (gpr_rd_data_0),
        .ex_fwd_en    (ex_fwd_en),
        .ex_is_load   (ex_is_load),
        .ex_dst_addr  (ex_dst_addr),
        .ex_fwd_data  (ex_fwd_data),
        .mem_fwd_en   (mem_fwd_en),
        .mem_dst_addr (mem_dst_addr),
        .mem_fwd_data (mem_fwd_data),
        .fwd_data     (ra_data)
    );

    id_fwd_mux u_fwd_rb (
        .src_addr     (rs2_addr),
        .gpr_data     (gpr_rd_data_1),
        .ex_fwd_en    (ex_fwd_en),
        .ex_is_load   (ex_is_load),
        .ex_dst_addr  (ex_dst_addr),
        .ex_fwd_data  (ex_fwd_data),
        .mem_fwd_en   (mem_fwd_en),
        .mem_dst_addr (mem_dst_addr),
        .mem_fwd_data (mem_fwd_data),
        .fwd_data     (rb_data)
    );

    // Immediate bits sitting in an rs field must not raise a false hazard.
    assign rs1_conflict = uses_rs1(opcode) && (ex_dst_addr == rs1_addr);
    assign rs2_conflict = uses_rs2(opcode) && (ex_dst_addr == rs2_addr);

    // Stays asserted under stall so upstream keeps holding IF/ID.
    assign ld_hazard = if_valid && ex_fwd_en && ex_is_load && (ex_dst_addr != '0)
                       && (rs1_conflict || rs2_conflict);

    // An empty IF/ID slot must never enable a register write.
    assign gpr_we_dec = (if_valid && writes_rd(opcode, rd_addr)) ? ENABLE_ : DISABLE_;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register update on the same edge.
        if (reset) begin
            id_ex_q <= ID_EX_RESET;
        end else if (flush) begin
            id_ex_q.valid   <= 1'b0;
            id_ex_q.gpr_we_ <= DISABLE_;
        end else if (!stall) begin
            if (ld_hazard) begin
                // Bubble; the consumer stays in IF/ID and retries next cycle.
                id_ex_q.valid   <= 1'b0;
                id_ex_q.gpr_we_ <= DISABLE_;
            end else begin
                id_ex_q.valid    <= if_valid;
                id_ex_q.pc       <= if_pc;
                id_ex_q.insn     <= if_insn;
                id_ex_q.ra_data  <= ra_data;
                id_ex_q.rb_data  <= rb_data;
                id_ex_q.dst_addr <= rd_addr;
                id_ex_q.gpr_we_  <= gpr_we_dec;
            end
        end
    end

    assign id_valid    = id_ex_q.valid;
    assign id_pc       = id_ex_q.pc;
    assign id_insn     = id_ex_q.insn;
    assign id_ra_data  = id_ex_q.ra_data;
    assign id_rb_data  = id_ex_q.rb_data;
    assign id_dst_addr = id_ex_q.dst_addr;
    assign id_gpr_we_  = id_ex_q.gpr_we_;

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios plus a
// random phase, with a reference model feeding an expected-value queue.
module tb_id_operand_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  dst;
        logic        we_n;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, if_valid, stall, flush;
    logic [31:0] if_pc, if_insn, gpr_rd_data_0, gpr_rd_data_1;
    logic        ex_fwd_en, ex_is_load, mem_fwd_en;
    logic [4:0]  ex_dst_addr, mem_dst_addr;
    logic [31:0] ex_fwd_data, mem_fwd_data;

    logic [4:0]  gpr_rd_addr_0, gpr_rd_addr_1, id_dst_addr;
    logic        ld_hazard, id_valid, id_gpr_we_;
    logic [31:0] id_pc, id_insn, id_ra_data, id_rb_data;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    exp_t m;

    always #5 clk = ~clk;

    id_operand_stage dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_insn(if_insn),
        .stall(stall), .flush(flush),
        .gpr_rd_addr_0(gpr_rd_addr_0), .gpr_rd_addr_1(gpr_rd_addr_1),
        .gpr_rd_data_0(gpr_rd_data_0), .gpr_rd_data_1(gpr_rd_data_1),
        .ex_fwd_en(ex_fwd_en), .ex_is_load(ex_is_load), .ex_dst_addr(ex_dst_addr),
        .ex_fwd_data(ex_fwd_data), .mem_fwd_en(mem_fwd_en), .mem_dst_addr(mem_dst_addr),
        .mem_fwd_data(mem_fwd_data), .ld_hazard(ld_hazard),
        .id_valid(id_valid), .id_pc(id_pc), .id_insn(id_insn),
        .id_ra_data(id_ra_data), .id_rb_data(id_rb_data),
        .id_dst_addr(id_dst_addr), .id_gpr_we_(id_gpr_we_)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_add(input logic [4:0] rd, rs1, rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] i_addi(input logic [4:0] rd, rs1, input logic [11:0] imm);
        return {imm, rs1, 3'd0, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] s_sw(input logic [4:0] rs2, rs1);
        return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
    endfunction
    function automatic logic [31:0] b_beq(input logic [4:0] rs1, rs2);
        return {7'd0, rs2, rs1, 3'd0, 5'd4, 7'b1100011};
    endfunction
    function automatic logic [31:0] u_lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0110111};
    endfunction
    function automatic logic [31:0] j_jal(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b1101111};
    endfunction

    // Operand value as the architecture defines it for this cycle.
    function automatic logic [31:0] model_operand(input logic [4:0] a, input logic [31:0] gpr);
        if (a == 5'd0) return 32'd0;
        if (ex_fwd_en && !ex_is_load && ex_dst_addr == a) return ex_fwd_data;
        if (mem_fwd_en && mem_dst_addr == a) return mem_fwd_data;
        return gpr;
    endfunction

    function automatic logic model_hazard();
        logic [6:0] op;
        logic       r1, r2;
        op = if_insn[6:0];
        r1 = (op != 7'b0110111) && (op != 7'b0010111) && (op != 7'b1101111)
             && (ex_dst_addr == if_insn[19:15]);
        r2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011)
             && (ex_dst_addr == if_insn[24:20]);
        return if_valid && ex_fwd_en && ex_is_load && (ex_dst_addr != 5'd0) && (r1 || r2);
    endfunction

    function automatic logic model_we_n();
        logic [6:0] op;
        op = if_insn[6:0];
        if (!if_valid || op == 7'b0100011 || op == 7'b1100011 || if_insn[11:7] == 5'd0)
            return 1'b1;
        return 1'b0;
    endfunction

    // One clock: check combinational outputs, advance the model, push the
    // expectation, then pop it and compare once the edge has happened.
    task automatic step();
        exp_t e;
        logic hz;
        #1;
        hz = model_hazard();
        check("ld_hazard", 32'(ld_hazard), 32'(hz));
        check("rd_addr_0", 32'(gpr_rd_addr_0), 32'(if_insn[19:15]));
        check("rd_addr_1", 32'(gpr_rd_addr_1), 32'(if_insn[24:20]));
        if (reset) begin
            m = '{valid: 1'b0, pc: 32'd0, insn: 32'h13, ra: 32'd0, rb: 32'd0, dst: 5'd0, we_n: 1'b1};
        end else if (flush) begin
            m.valid = 1'b0;
            m.we_n  = 1'b1;
        end else if (stall) begin
            m = m;
        end else if (hz) begin
            m.valid = 1'b0;
            m.we_n  = 1'b1;
        end else begin
            m.valid = if_valid;
            m.pc    = if_pc;
            m.insn  = if_insn;
            m.ra    = model_operand(if_insn[19:15], gpr_rd_data_0);
            m.rb    = model_operand(if_insn[24:20], gpr_rd_data_1);
            m.dst   = if_insn[11:7];
            m.we_n  = model_we_n();
        end
        sb_q.push_back(m);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("id_valid", 32'(id_valid), 32'(e.valid));
        check("id_gpr_we_", 32'(id_gpr_we_), 32'(e.we_n));
        check("id_insn", id_insn, e.insn);
        check("id_pc", id_pc, e.pc);
        check("id_ra_data", id_ra_data, e.ra);
        check("id_rb_data", id_rb_data, e.rb);
        check("id_dst_addr", 32'(id_dst_addr), 32'(e.dst));
    endtask

    task automatic quiet();
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        ex_fwd_en = 1'b0; ex_is_load = 1'b0; ex_dst_addr = 5'd0; ex_fwd_data = 32'd0;
        mem_fwd_en = 1'b0; mem_dst_addr = 5'd0; mem_fwd_data = 32'd0;
    endtask

    task automatic slot(input logic v, input logic [31:0] pc, input logic [31:0] insn);
        if_valid = v; if_pc = pc; if_insn = insn;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        quiet();
        slot(1'b0, 32'd0, 32'h13);
        gpr_rd_data_0 = 32'd0; gpr_rd_data_1 = 32'd0;

        // Reset for two cycles.
        reset = 1'b1;
        step(); step();
        reset = 1'b0;

        // EX forward on rs1; rs2 from gpr.
        slot(1'b1, 32'h100, r_add(5'd3, 5'd1, 5'd2));
        gpr_rd_data_0 = 32'd5; gpr_rd_data_1 = 32'd7;
        ex_fwd_en = 1'b1; ex_dst_addr = 5'd1; ex_fwd_data = 32'h10;
        step();
        check("fwd_ex_ra", id_ra_data, 32'h10);
        check("fwd_ex_we", 32'(id_gpr_we_), 32'd0);

        // EX beats MEM for the same register.
        slot(1'b1, 32'h104, r_add(5'd4, 5'd1, 5'd2));
        ex_dst_addr = 5'd2; ex_fwd_data = 32'hAA;
        mem_fwd_en = 1'b1; mem_dst_addr = 5'd2; mem_fwd_data = 32'hBB;
        step();
        check("prio_rb", id_rb_data, 32'hAA);

        // x0 source ignores a bypass targeting x0.
        slot(1'b1, 32'h108, r_add(5'd5, 5'd0, 5'd0));
        gpr_rd_data_0 = 32'h99; gpr_rd_data_1 = 32'h99;
        ex_dst_addr = 5'd0; ex_fwd_data = 32'h55; mem_dst_addr = 5'd0;
        step();
        check("x0_ra", id_ra_data, 32'd0);

        // Load-use: one bubble, then MEM supplies the value.
        quiet();
        slot(1'b1, 32'h10C, r_add(5'd6, 5'd5, 5'd1));
        gpr_rd_data_0 = 32'h0; gpr_rd_data_1 = 32'h3;
        ex_fwd_en = 1'b1; ex_is_load = 1'b1; ex_dst_addr = 5'd5; ex_fwd_data = 32'hDEAD;
        step();
        quiet();
        mem_fwd_en = 1'b1; mem_dst_addr = 5'd5; mem_fwd_data = 32'h1234;
        step();
        check("ldu_ra", id_ra_data, 32'h1234);

        // Flush together with stall kills the slot.
        quiet();
        slot(1'b1, 32'h110, r_add(5'd7, 5'd1, 5'd2));
        step();
        flush = 1'b1; stall = 1'b1;
        step();
        // Stall alone holds for three cycles while inputs change.
        quiet();
        slot(1'b1, 32'h114, r_add(5'd8, 5'd1, 5'd2));
        gpr_rd_data_0 = 32'h11; gpr_rd_data_1 = 32'h22;
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            slot(1'b1, 32'h200 + 32'(i * 4), r_add(5'd9, 5'd3, 5'd4));
            gpr_rd_data_0 = 32'(i); gpr_rd_data_1 = 32'(i + 10);
            step();
        end
        check("stall_hold_pc", id_pc, 32'h114);

        // Store: no write; store data register hits an EX load -> hazard.
        quiet();
        slot(1'b1, 32'h120, s_sw(5'd2, 5'd1));
        step();
        check("sw_we", 32'(id_gpr_we_), 32'd1);
        ex_fwd_en = 1'b1; ex_is_load = 1'b1; ex_dst_addr = 5'd2;
        step();

        // Immediate fields must not trigger hazards.
        slot(1'b1, 32'h124, u_lui(5'd4, 20'h00010));   // rs1 field = x2
        step();
        slot(1'b1, 32'h128, i_addi(5'd7, 5'd5, 12'd2)); // rs2 field = x2
        step();
        slot(1'b1, 32'h12C, j_jal(5'd1, 20'h00010));    // rs1 field = x2
        step();

        // Invalid slot: bubble, no hazard.
        slot(1'b0, 32'h130, r_add(5'd3, 5'd2, 5'd2));
        step();

        // Stall beats hazard, hazard still driven; then bubble.
        quiet();
        slot(1'b1, 32'h134, r_add(5'd3, 5'd1, 5'd1));
        step();
        stall = 1'b1;
        slot(1'b1, 32'h138, b_beq(5'd6, 5'd1));
        ex_fwd_en = 1'b1; ex_is_load = 1'b1; ex_dst_addr = 5'd1;
        step();
        stall = 1'b0;
        step();

        // rd = x0 never writes.
        quiet();
        slot(1'b1, 32'h13C, r_add(5'd0, 5'd1, 5'd2));
        step();

        // Reset mid-stream wins over stall and flush.
        slot(1'b1, 32'h140, r_add(5'd3, 5'd1, 5'd2));
        step();
        reset = 1'b1; stall = 1'b1; flush = 1'b1;
        step();
        quiet();

        // Random traffic over a small register set to provoke matches.
        for (int n = 0; n < 120; n++) begin
            logic [4:0] a, b, c;
            a = 5'($urandom_range(0, 3));
            b = 5'($urandom_range(0, 3));
            c = 5'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: if_insn = r_add(a, b, c);
                1: if_insn = i_addi(a, b, 12'($urandom_range(0, 3)));
                2: if_insn = s_sw(b, c);
                3: if_insn = b_beq(b, c);
                4: if_insn = u_lui(a, 20'($urandom_range(0, 31) << 3));
                default: if_insn = j_jal(a, 20'($urandom_range(0, 31) << 3));
            endcase
            if_valid      = ($urandom_range(0, 7) != 0);
            if_pc         = $urandom;
            reset         = ($urandom_range(0, 29) == 0);
            flush         = ($urandom_range(0, 7) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            gpr_rd_data_0 = $urandom;
            gpr_rd_data_1 = $urandom;
            ex_fwd_en     = $urandom_range(0, 1) != 0;
            ex_is_load    = $urandom_range(0, 2) == 0;
            ex_dst_addr   = 5'($urandom_range(0, 3));
            ex_fwd_data   = $urandom;
            mem_fwd_en    = $urandom_range(0, 1) != 0;
            mem_dst_addr  = 5'($urandom_range(0, 3));
            mem_fwd_data  = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
